// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and constants for the instruction-memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PAD, RELEASE, RUN} state_e;
  localparam logic [7:0] NOP_BYTE = 8'h00;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams a big-endian byte image into the instruction file, pads to a word, then releases the core
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_BYTES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_BYTES);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d, xfer;
  assign s_ready    = state_q == LOAD;
  assign xfer       = s_valid && s_ready;
  assign imem_we    = xfer || state_q == PAD;
  assign imem_wdata = state_q == PAD ? NOP_BYTE : s_data;
  assign imem_addr  = addr_q;
  assign cpu_reset  = state_q != RUN;
  assign done       = state_q == RUN;
  assign error      = err_q;
  assign byte_count = cnt_q;
  assign cnt_inc    = cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    addr_d  = imem_we ? addr_q + 1'b1 : addr_q;
    cnt_d   = imem_we ? cnt_inc : cnt_q;
    err_d   = err_q;
    if ((state_q == IDLE || state_q == RUN) && load_start) begin
      state_d = LOAD;
      addr_d  = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (xfer && s_last) begin
      state_d = cnt_inc[1:0] == 2'b00 ? RELEASE : PAD;
    end else if (xfer && cnt_inc == MAX_CNT) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (state_q == PAD && addr_q[1:0] == 2'(WORD_BYTES-1)) begin
      state_d = RELEASE;
    end else if (state_q == RELEASE) begin
      state_d = RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the loader against hand-computed expectations
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       reset, load_start, s_valid, s_last;
  logic [7:0] s_data;
  logic       s_ready, imem_we, cpu_reset, done, error;
  logic [7:0] imem_addr, imem_wdata;
  logic [8:0] byte_count;
  logic       o_ready, o_we, o_cpu_reset, o_done, o_error;
  logic [3:0] o_addr;
  logic [7:0] o_wdata;
  logic [4:0] o_count;
  logic [7:0] mem [256];
  logic [7:0] omem [16];
  logic [7:0] img [20] = '{8'h02, 8'h32, 8'h80, 8'h20, 8'h02, 8'h13, 8'hA0, 8'h22, 8'hAE, 8'h34,
                           8'h00, 8'h20, 8'h8E, 8'h28, 8'h00, 8'h20, 8'h12, 8'h88, 8'hFF, 8'hFB};
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  imem_loader u_dut (
    .clk(clk), .reset(reset), .load_start(load_start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
    .byte_count(byte_count)
  );
  imem_loader #(.ADDR_W(4), .MAX_BYTES(8)) u_ovf (
    .clk(clk), .reset(reset), .load_start(load_start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(o_ready), .imem_we(o_we), .imem_addr(o_addr),
    .imem_wdata(o_wdata), .cpu_reset(o_cpu_reset), .done(o_done), .error(o_error),
    .byte_count(o_count)
  );
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    for (int i = 0; i < 16; i++) omem[i] = 8'hEE;
  end
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    if (o_we) omem[o_addr] <= o_wdata;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic put(input logic [7:0] d, input logic l, input int a);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    chk("xfer_we", 32'(imem_we), 1);
    chk("xfer_addr", 32'(imem_addr), a);
    chk("xfer_wdata", 32'(imem_wdata), 32'(d));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask
  task automatic start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask
  function automatic logic [31:0] word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction
  initial begin
    reset = 1'b0; load_start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_count", 32'(byte_count), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    reset = 1'b1;
    start();
    #1;
    chk("load_ready", 32'(s_ready), 1);
    chk("load_cpu_reset", 32'(cpu_reset), 1);
    for (int i = 0; i < 20; i++) put(img[i], i == 19, i);
    #1;
    chk("img20_release_cpu_reset", 32'(cpu_reset), 1);
    chk("img20_release_done", 32'(done), 0);
    chk("img20_count", 32'(byte_count), 20);
    chk("img20_no_pad", 32'(imem_we), 0);
    @(negedge clk); #1;
    chk("img20_run_cpu_reset", 32'(cpu_reset), 0);
    chk("img20_run_done", 32'(done), 1);
    chk("img20_word0", word(0), 32'h02328020);
    chk("img20_word16", word(16), 32'h1288FFFB);
    start();
    #1;
    chk("restart_cpu_reset", 32'(cpu_reset), 1);
    chk("restart_ready", 32'(s_ready), 1);
    chk("restart_count", 32'(byte_count), 0);
    for (int i = 0; i < 6; i++) put(8'(8'h11 * (i + 1)), i == 5, i);
    #1;
    chk("pad0_we", 32'(imem_we), 1);
    chk("pad0_addr", 32'(imem_addr), 6);
    chk("pad0_wdata", 32'(imem_wdata), 0);
    chk("pad0_ready", 32'(s_ready), 0);
    @(negedge clk); #1;
    chk("pad1_we", 32'(imem_we), 1);
    chk("pad1_addr", 32'(imem_addr), 7);
    @(negedge clk); #1;
    chk("pad_release_cpu_reset", 32'(cpu_reset), 1);
    chk("pad_release_we", 32'(imem_we), 0);
    chk("pad_count", 32'(byte_count), 8);
    @(negedge clk); #1;
    chk("pad_run_done", 32'(done), 1);
    chk("pad_word0", word(0), 32'h11223344);
    chk("pad_word4", word(4), 32'h55660000);
    start();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("gap_we", 32'(imem_we), 0);
      @(negedge clk);
      put(8'(8'hA0 + i), i == 7, i);
    end
    #1;
    chk("gap_count", 32'(byte_count), 8);
    @(negedge clk); #1;
    chk("gap_done", 32'(done), 1);
    chk("gap_word0", word(0), 32'hA0A1A2A3);
    chk("gap_word4", word(4), 32'hA4A5A6A7);
    start();
    for (int i = 0; i < 3; i++) put(8'(8'hC0 + i), 1'b0, i);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_ready", 32'(s_ready), 0);
    chk("abort_count", 32'(byte_count), 0);
    chk("abort_cpu_reset", 32'(cpu_reset), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_partial", 32'(mem[2]), 32'hC2);
    start();
    put(8'h5A, 1'b0, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    start();
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i + 1);
      @(negedge clk);
    end
    #1;
    chk("ovf_error", 32'(o_error), 1);
    chk("ovf_ready", 32'(o_ready), 0);
    chk("ovf_cpu_reset", 32'(o_cpu_reset), 1);
    chk("ovf_done", 32'(o_done), 0);
    chk("ovf_count", 32'(o_count), 8);
    s_data = 8'h99;
    #1;
    chk("ovf_byte9_we", 32'(o_we), 0);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("ovf_byte9_mem", 32'(omem[8]), 32'hEE);
    chk("ovf_byte8_mem", 32'(omem[7]), 8);
    chk("ovf_error_hold", 32'(o_error), 1);
    start();
    #1;
    chk("ovf_error_clear", 32'(o_error), 0);
    chk("ovf_reload_ready", 32'(o_ready), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
